// File: rtl/fetch_sequencer_if.sv
// Control bundle between the fetch sequencer and the fetch/decode datapath.
// The master side is the sequencer; the slave side is the fetch unit and decode logic.
interface fetch_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int SREG_W = 8
);
  logic              stall;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] pmdata;
  logic [SREG_W-1:0] sreg;
  logic              load_ir;
  logic              load_pc;
  logic [1:0]        mode_12k;
  logic [1:0]        mode_add_za;
  logic              mode_pcz;
  logic [DATA_W-1:0] k;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] lpm_data;
  logic              lpm_valid;
  logic [1:0]        state;

  modport master (
    input  stall, ir, pmdata, sreg,
    output load_ir, load_pc, mode_12k, mode_add_za, mode_pcz, k,
           push, pop, lpm_data, lpm_valid, state
  );

  modport slave (
    output stall, ir, pmdata, sreg,
    input  load_ir, load_pc, mode_12k, mode_add_za, mode_pcz, k,
           push, pop, lpm_data, lpm_valid, state
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program-flow sequencer for the fetch unit: PC redirects, two-word JMP and LPM.
// Define FETCH_SEQ_LPM_EN to enable LPM; otherwise LPM issues as an ordinary instruction.
//
// state | meaning
// FETCH | refill IR after a redirect, PC <= PC+1
// EXEC  | decode IR; ordinary instructions issue one per cycle
// JMP2  | second JMP word captured, load absolute target
module fetch_sequencer #(
  parameter int DATA_W = 16,
  parameter int SREG_W = 8
) (
  input  logic                i_clk,
  input  logic                i_reset,
  fetch_sequencer_if.master   bus
);
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    JMP2  = 2'd2
  } state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] k_q;
  logic [DATA_W-1:0] k_out;
  logic              jmp_cap;
  logic              load_ir, load_pc, push, pop, mode_pcz;
  logic [1:0]        mode_12k, mode_add_za;

  logic is_rel, is_rcall, is_ret, is_ijmp, is_jmp, br_taken;

  assign is_rel   = (bus.ir[15:13] == 3'b110);
  assign is_rcall = (bus.ir[15:12] == 4'hD);
  assign is_ret   = (bus.ir == 16'h9508);
  assign is_ijmp  = (bus.ir == 16'h9409);
  assign is_jmp   = (bus.ir[15:9] == 7'b1001010) && (bus.ir[3:1] == 3'b110);
  // BRBS (IR[10]=0) takes on a set flag, BRBC (IR[10]=1) on a clear flag
  assign br_taken = (bus.ir[15:11] == 5'b11110) && (bus.sreg[bus.ir[2:0]] == ~bus.ir[10]);

`ifdef FETCH_SEQ_LPM_EN
  logic              is_lpm;
  logic              lpm_cap;
  logic [DATA_W-1:0] lpm_q;
  assign is_lpm = (bus.ir == 16'h95C8);
`endif

  always_comb begin
    state_nx    = state;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    mode_12k    = 2'b00;
    mode_add_za = 2'b00;
    mode_pcz    = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    jmp_cap     = 1'b0;
    k_out       = i_reset ? '0 : k_q;
`ifdef FETCH_SEQ_LPM_EN
    lpm_cap     = 1'b0;
`endif
    if (!i_reset && !bus.stall) begin
      unique case (state)
        FETCH: begin
          load_ir  = 1'b1;
          load_pc  = 1'b1;
          state_nx = EXEC;
        end
        EXEC: begin
          if (is_rel) begin
            load_pc  = 1'b1;
            mode_12k = 2'b10;
            k_out    = bus.ir;
            push     = is_rcall;
            state_nx = FETCH;
          end else if (is_ret) begin
            pop         = 1'b1;
            load_pc     = 1'b1;
            mode_add_za = 2'b11;
            state_nx    = FETCH;
          end else if (is_ijmp) begin
            load_pc     = 1'b1;
            mode_add_za = 2'b10;
            state_nx    = FETCH;
          end else if (is_jmp) begin
            jmp_cap  = 1'b1;
            state_nx = JMP2;
          end else if (br_taken) begin
            load_pc  = 1'b1;
            mode_12k = 2'b11;
            k_out    = bus.ir >> 3;
            state_nx = FETCH;
`ifdef FETCH_SEQ_LPM_EN
          end else if (is_lpm) begin
            mode_pcz = 1'b1;
            lpm_cap  = 1'b1;
            state_nx = FETCH;
`endif
          end else begin
            load_ir = 1'b1;
            load_pc = 1'b1;
          end
        end
        JMP2: begin
          load_pc     = 1'b1;
          mode_add_za = 2'b01;
          state_nx    = FETCH;
        end
        default: state_nx = FETCH;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= FETCH;
      k_q   <= '0;
    end else if (!bus.stall) begin
      state <= state_nx;
      k_q   <= jmp_cap ? bus.pmdata : k_out;
    end
  end

`ifdef FETCH_SEQ_LPM_EN
  always_ff @(posedge i_clk) begin
    if (i_reset)      lpm_q <= '0;
    else if (lpm_cap) lpm_q <= bus.pmdata;
  end
  // bypass so the word is visible in the same cycle as the valid strobe
  assign bus.lpm_valid = lpm_cap;
  assign bus.lpm_data  = i_reset ? '0 : (lpm_cap ? bus.pmdata : lpm_q);
`else
  assign bus.lpm_valid = 1'b0;
  assign bus.lpm_data  = '0;
`endif

  assign bus.load_ir     = load_ir;
  assign bus.load_pc     = load_pc;
  assign bus.mode_12k    = mode_12k;
  assign bus.mode_add_za = mode_add_za;
  assign bus.mode_pcz    = mode_pcz;
  assign bus.push        = push;
  assign bus.pop         = pop;
  assign bus.k           = k_out;
  assign bus.state       = i_reset ? FETCH : state;
endmodule
